// File: rtl/mem_fill_engine_if.sv
// Write-port bundle between the controller, the fill engine and working memory.
// Carries the rdy/en handshake, fill configuration and the memory write strobe.
`timescale 1ns/1ps
interface mem_fill_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              rdy;
  logic [1:0]        mode;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] step;
  logic              abort;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;
  logic              done;

  modport master (
    output en, mode, fill_val, step, abort,
    input  rdy, addr, wrdata, wren, done
  );

  modport slave (
    input  en, mode, fill_val, step, abort,
    output rdy, addr, wrdata, wren, done
  );
endinterface

// File: rtl/mem_fill_engine.sv
// Sweeps a single-port memory writing one word per cycle over 0..DEPTH-1,
// with identity, constant, ramp and descending patterns plus abort.
`timescale 1ns/1ps
module mem_fill_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic clk,
  input logic rst_n,
  mem_fill_engine_if.slave bus
);

  typedef enum logic {IDLE, FILL} state_t;
  typedef enum logic [1:0] {M_IDENTITY = 2'd0, M_CONST = 2'd1, M_RAMP = 2'd2, M_DESC = 2'd3} mode_t;

  // Terminating on addr == DEPTH-1 means the counter never has to hold DEPTH.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       LAST32    = 32'(DEPTH - 1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              wren_q, wren_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] ramp_next;

  function automatic logic [DATA_W-1:0] pattern(
    input mode_t             m,
    input logic [ADDR_W-1:0] k,
    input logic [DATA_W-1:0] cval,
    input logic [DATA_W-1:0] ramp
  );
    logic [31:0] desc;
    desc = LAST32 - 32'(k);
    case (m)
      M_IDENTITY: pattern = DATA_W'(k);
      M_CONST:    pattern = cval;
      M_RAMP:     pattern = ramp;
      default:    pattern = DATA_W'(desc);
    endcase
  endfunction

  assign addr_inc  = addr_q + ADDR_W'(1);
  // The ramp reuses the previously written word as its accumulator.
  assign ramp_next = wrdata_q + step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= M_IDENTITY;
      fill_q   <= '0;
      step_q   <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      step_q   <= step_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    step_d   = step_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    rdy_d    = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d  = FILL;
          mode_d   = mode_t'(bus.mode);
          fill_d   = bus.fill_val;
          step_d   = bus.step;
          addr_d   = '0;
          wrdata_d = pattern(mode_t'(bus.mode), '0, bus.fill_val, bus.fill_val);
          wren_d   = 1'b1;
          rdy_d    = 1'b0;
        end
      end
      FILL: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d   = addr_inc;
          wrdata_d = pattern(mode_q, addr_inc, fill_q, ramp_next);
          wren_d   = 1'b1;
          rdy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdy    = rdy_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mem_fill_engine.sv
// Directed bench: a 256x8 engine for the main modes plus a 16-deep engine
// for the descending pattern, each writing into a behavioural memory.
`timescale 1ns/1ps
module tb_mem_fill_engine;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_fill_engine_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
  mem_fill_engine_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();

  mem_fill_engine #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mem_fill_engine #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  int         wcnt_a = 0;
  int         wcnt_b = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories commit whatever the engine presents at each edge.
  always @(posedge clk) begin
    if (bus_a.wren) begin
      mem_a[bus_a.addr] <= bus_a.wrdata;
      wcnt_a <= wcnt_a + 1;
    end
    if (bus_b.wren) begin
      mem_b[bus_b.addr] <= bus_b.wrdata;
      wcnt_b <= wcnt_b + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] fv, input logic [7:0] st,
                               input bit holdEn);
    bus_a.mode     = m;
    bus_a.fill_val = fv;
    bus_a.step     = st;
    bus_a.en       = 1'b1;
    @(negedge clk);
    if (!holdEn) bus_a.en = 1'b0;
  endtask

  // Walks a running fill on engine A until rdy returns, with a cycle budget.
  task automatic runFill(input int dropEnAt, input bit disturb,
                         output int low, output int dones, output int badAddr);
    low = 0; dones = 0; badAddr = 0;
    while (bus_a.rdy === 1'b0 && low < 600) begin
      if (bus_a.addr !== 8'(low)) badAddr++;
      if (bus_a.done) dones++;
      if (low == dropEnAt) bus_a.en = 1'b0;
      if (disturb && low == 3) begin
        bus_a.mode = 2'd1; bus_a.fill_val = 8'h00; bus_a.step = 8'h07; bus_a.en = 1'b1;
      end
      if (disturb && low == 5) bus_a.en = 1'b0;
      low++;
      @(negedge clk);
    end
  endtask

  initial begin
    int low, dones, bad, wc0;
    rst_n = 1'b0;
    bus_a.en = 0; bus_a.mode = 0; bus_a.fill_val = 0; bus_a.step = 0; bus_a.abort = 0;
    bus_b.en = 0; bus_b.mode = 0; bus_b.fill_val = 0; bus_b.step = 0; bus_b.abort = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_rdy",    32'(bus_a.rdy),    32'd1);
    checkOutput("rst_wren",   32'(bus_a.wren),   32'd0);
    checkOutput("rst_addr",   32'(bus_a.addr),   32'd0);
    checkOutput("rst_wrdata", 32'(bus_a.wrdata), 32'd0);
    checkOutput("rst_done",   32'(bus_a.done),   32'd0);
    checkOutput("rst_rdy_b",  32'(bus_b.rdy),    32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] abort while idle");
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    checkOutput("idle_abort_rdy",  32'(bus_a.rdy),  32'd1);
    checkOutput("idle_abort_wren", 32'(bus_a.wren), 32'd0);

    $display("[TB] identity fill");
    wc0 = wcnt_a;
    applyStimulus(2'd0, 8'h00, 8'h00, 1'b0);
    checkOutput("id_start_wren", 32'(bus_a.wren), 32'd1);
    checkOutput("id_start_rdy",  32'(bus_a.rdy),  32'd0);
    runFill(-1, 1'b0, low, dones, bad);
    checkOutput("id_low_cycles", 32'(low),   32'd256);
    checkOutput("id_early_done", 32'(dones), 32'd0);
    checkOutput("id_addr_seq",   32'(bad),   32'd0);
    checkOutput("id_done",       32'(bus_a.done), 32'd1);
    checkOutput("id_end_wren",   32'(bus_a.wren), 32'd0);
    @(negedge clk);
    checkOutput("id_done_fall",  32'(bus_a.done),   32'd0);
    checkOutput("id_hold_addr",  32'(bus_a.addr),   32'hFF);
    checkOutput("id_hold_data",  32'(bus_a.wrdata), 32'hFF);
    checkOutput("id_writes",     32'(wcnt_a - wc0), 32'd256);
    checkOutput("id_mem0",       32'(mem_a[0]),     32'h00);
    checkOutput("id_mem127",     32'(mem_a[127]),   32'h7F);
    checkOutput("id_mem255",     32'(mem_a[255]),   32'hFF);

    $display("[TB] ramp fill with mid-fill input changes");
    applyStimulus(2'd2, 8'hF0, 8'h03, 1'b0);
    runFill(-1, 1'b1, low, dones, bad);
    checkOutput("ramp_low",    32'(low),         32'd256);
    checkOutput("ramp_seq",    32'(bad),         32'd0);
    checkOutput("ramp_done",   32'(bus_a.done),  32'd1);
    checkOutput("ramp_mem0",   32'(mem_a[0]),    32'hF0);
    checkOutput("ramp_mem1",   32'(mem_a[1]),    32'hF3);
    checkOutput("ramp_mem5",   32'(mem_a[5]),    32'hFF);
    checkOutput("ramp_mem6",   32'(mem_a[6]),    32'h02);
    checkOutput("ramp_mem100", 32'(mem_a[100]),  32'h1C);
    checkOutput("ramp_mem255", 32'(mem_a[255]),  32'hED);
    @(negedge clk);

    $display("[TB] const fill aborted at k=10");
    wc0 = wcnt_a;
    applyStimulus(2'd1, 8'hA5, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("abort_addr10", 32'(bus_a.addr), 32'd10);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    checkOutput("abort_rdy",  32'(bus_a.rdy),  32'd1);
    checkOutput("abort_wren", 32'(bus_a.wren), 32'd0);
    checkOutput("abort_done", 32'(bus_a.done), 32'd0);
    @(negedge clk);
    checkOutput("abort_done_after", 32'(bus_a.done),   32'd0);
    checkOutput("abort_writes",     32'(wcnt_a - wc0), 32'd11);
    checkOutput("abort_mem0",       32'(mem_a[0]),     32'hA5);
    checkOutput("abort_mem10",      32'(mem_a[10]),    32'hA5);
    checkOutput("abort_mem11",      32'(mem_a[11]),    32'h11);
    checkOutput("abort_mem255",     32'(mem_a[255]),   32'hED);

    $display("[TB] restart with en and abort together");
    bus_a.abort = 1'b1;
    applyStimulus(2'd1, 8'h3C, 8'h00, 1'b0);
    bus_a.abort = 1'b0;
    checkOutput("restart_rdy",  32'(bus_a.rdy),  32'd0);
    checkOutput("restart_wren", 32'(bus_a.wren), 32'd1);
    runFill(-1, 1'b0, low, dones, bad);
    checkOutput("restart_low",    32'(low),        32'd256);
    checkOutput("restart_done",   32'(bus_a.done), 32'd1);
    checkOutput("restart_mem200", 32'(mem_a[200]), 32'h3C);
    @(negedge clk);

    $display("[TB] async reset mid-fill");
    applyStimulus(2'd0, 8'h00, 8'h00, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("rstmid_addr100", 32'(bus_a.addr), 32'd100);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    checkOutput("rstmid_rdy",  32'(bus_a.rdy),  32'd1);
    checkOutput("rstmid_wren", 32'(bus_a.wren), 32'd0);
    checkOutput("rstmid_addr", 32'(bus_a.addr), 32'd0);
    wc0 = wcnt_a;
    repeat (5) @(negedge clk);
    checkOutput("rstmid_no_writes", 32'(wcnt_a - wc0), 32'd0);
    checkOutput("rstmid_still_rdy", 32'(bus_a.rdy),    32'd1);

    $display("[TB] en held high back-to-back");
    applyStimulus(2'd0, 8'h00, 8'h00, 1'b1);
    runFill(-1, 1'b0, low, dones, bad);
    checkOutput("b2b_low1",      32'(low),        32'd256);
    checkOutput("b2b_seq1",      32'(bad),        32'd0);
    checkOutput("b2b_idle_rdy",  32'(bus_a.rdy),  32'd1);
    checkOutput("b2b_idle_wren", 32'(bus_a.wren), 32'd0);
    checkOutput("b2b_done",      32'(bus_a.done), 32'd1);
    @(negedge clk);
    checkOutput("b2b_restart_rdy",  32'(bus_a.rdy),  32'd0);
    checkOutput("b2b_restart_wren", 32'(bus_a.wren), 32'd1);
    checkOutput("b2b_restart_addr", 32'(bus_a.addr), 32'd0);
    runFill(10, 1'b0, low, dones, bad);
    checkOutput("b2b_low2", 32'(low), 32'd256);
    checkOutput("b2b_seq2", 32'(bad), 32'd0);
    @(negedge clk);
    checkOutput("b2b_stop_rdy",  32'(bus_a.rdy),  32'd1);
    checkOutput("b2b_stop_wren", 32'(bus_a.wren), 32'd0);

    $display("[TB] descending fill, depth 16");
    wc0 = wcnt_b;
    bus_b.mode = 2'd3;
    bus_b.en   = 1'b1;
    @(negedge clk);
    bus_b.en = 1'b0;
    checkOutput("desc_start_addr", 32'(bus_b.addr),   32'd0);
    checkOutput("desc_start_data", 32'(bus_b.wrdata), 32'd15);
    low = 0; bad = 0; dones = 0;
    while (bus_b.rdy === 1'b0 && low < 100) begin
      if (bus_b.addr !== 4'(low)) bad++;
      if (bus_b.done) dones++;
      low++;
      @(negedge clk);
    end
    checkOutput("desc_low",    32'(low),         32'd16);
    checkOutput("desc_seq",    32'(bad),         32'd0);
    checkOutput("desc_early",  32'(dones),       32'd0);
    checkOutput("desc_done",   32'(bus_b.done),  32'd1);
    checkOutput("desc_writes", 32'(wcnt_b - wc0), 32'd16);
    checkOutput("desc_mem0",   32'(mem_b[0]),    32'd15);
    checkOutput("desc_mem7",   32'(mem_b[7]),    32'd8);
    checkOutput("desc_mem15",  32'(mem_b[15]),   32'd0);
    @(negedge clk);
    checkOutput("desc_hold_addr", 32'(bus_b.addr), 32'd15);
    checkOutput("desc_done_fall", 32'(bus_b.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
